// File: rtl/ili9341_spi_sink.sv
// ILI9341 panel-side SPI sink: deserialises {dc, byte} and decodes sleep/display/CASET/PASET/RAMWR.
// Latency: byte_valid 4 clk after the clk edge sampling sclk high for bit 0; pix_valid 1 clk after the low byte.
// No backpressure: the SPI master cannot be stalled; every byte is consumed the cycle byte_valid is high.
//
// Ports:
//   clk, rst_n                        system clock, async active-low reset
//   spi_sclk/mosi/cs_n/dc             raw SPI inputs (mode 0, asynchronous to clk)
//   byte_valid/byte_data/byte_dc      received byte strobe
//   cmd_valid/last_cmd                command strobe and most recent command
//   sleep_out/disp_on                 panel power/display state
//   win_xs/win_xe/win_ys/win_ye       address window
//   pix_valid/pix_x/pix_y/pix_data    RGB565 pixel write strobe with coordinates
module ili9341_spi_sink #(
    parameter int X_MAX = 239,
    parameter int Y_MAX = 319
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    input  logic        spi_dc,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic [7:0]  last_cmd,
    output logic        sleep_out,
    output logic        disp_on,
    output logic [8:0]  win_xs,
    output logic [8:0]  win_xe,
    output logic [8:0]  win_ys,
    output logic [8:0]  win_ye,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data
);

    localparam logic [15:0] XM16 = 16'(X_MAX);
    localparam logic [15:0] YM16 = 16'(Y_MAX);

    typedef enum logic [1:0] {CMD_WAIT, PARAM, RAMWR_HI, RAMWR_LO} state_t;

    // ---------------- input synchronisers ----------------
    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;
    logic cs_s1_q, cs_s2_q;
    logic dc_s1_q, dc_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            dc_s1_q     <= 1'b0;
            dc_s2_q     <= 1'b0;
        end else begin
            sclk_s1_q   <= spi_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
            cs_s1_q     <= spi_cs_n;
            cs_s2_q     <= cs_s1_q;
            dc_s1_q     <= spi_dc;
            dc_s2_q     <= dc_s1_q;
        end
    end

    logic sclk_rise;
    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;

    // ---------------- bit capture ----------------
    // done_q / done2_q pad the path so byte_valid lands 4 clk after bit 0 is first sampled.
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       done_q, done2_q, dc_lat_q;
    logic       byte_valid_q, byte_dc_q, cmd_valid_q;
    logic [7:0] byte_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            done_q       <= 1'b0;
            done2_q      <= 1'b0;
            dc_lat_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cs_s2_q) begin
                // Deselect drops a partial byte; decode context is untouched.
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                shift_q   <= {shift_q[6:0], mosi_s2_q};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    done_q   <= 1'b1;
                    dc_lat_q <= dc_s2_q;
                end
            end
            done2_q      <= done_q;
            byte_valid_q <= done2_q;
            cmd_valid_q  <= done2_q & ~dc_lat_q;
            if (done2_q) begin
                byte_data_q <= shift_q;
                byte_dc_q   <= dc_lat_q;
            end
        end
    end

    // ---------------- decoder ----------------
    state_t      state_q;
    logic        is_paset_q;
    logic [2:0]  pidx_q;
    logic [7:0]  p0_q, p1_q, p2_q, hi_q;
    logic [8:0]  cur_x_q, cur_y_q;
    logic [8:0]  cur_x_d, cur_y_d;
    logic [8:0]  win_xs_q, win_xe_q, win_ys_q, win_ye_q;
    logic [7:0]  last_cmd_q;
    logic        sleep_q, disp_q;
    logic        pix_valid_q;
    logic [8:0]  pix_x_q, pix_y_q;
    logic [15:0] pix_data_q;
    logic        win_ok;

    function automatic logic [8:0] clamp(input logic [15:0] v, input logic [15:0] m);
        return (v > m) ? m[8:0] : v[8:0];
    endfunction

    assign win_ok = (win_xs_q <= win_xe_q) && (win_ys_q <= win_ye_q);

    // Raster advance with wrap to the window origin after the last pixel.
    always_comb begin
        cur_x_d = cur_x_q + 9'd1;
        cur_y_d = cur_y_q;
        if (cur_x_q == win_xe_q) begin
            cur_x_d = win_xs_q;
            cur_y_d = (cur_y_q == win_ye_q) ? win_ys_q : cur_y_q + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CMD_WAIT;
            is_paset_q  <= 1'b0;
            pidx_q      <= 3'd0;
            p0_q        <= 8'h00;
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            hi_q        <= 8'h00;
            cur_x_q     <= 9'd0;
            cur_y_q     <= 9'd0;
            win_xs_q    <= 9'd0;
            win_xe_q    <= XM16[8:0];
            win_ys_q    <= 9'd0;
            win_ye_q    <= YM16[8:0];
            last_cmd_q  <= 8'h00;
            sleep_q     <= 1'b0;
            disp_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 9'd0;
            pix_y_q     <= 9'd0;
            pix_data_q  <= 16'h0000;
        end else begin
            pix_valid_q <= 1'b0;
            if (byte_valid_q && !byte_dc_q) begin
                // Commands win in every state; a pending odd RAMWR byte is simply dropped.
                last_cmd_q <= byte_data_q;
                pidx_q     <= 3'd0;
                state_q    <= CMD_WAIT;
                case (byte_data_q)
                    8'h10: sleep_q <= 1'b0;
                    8'h11: sleep_q <= 1'b1;
                    8'h28: disp_q  <= 1'b0;
                    8'h29: disp_q  <= 1'b1;
                    8'h2A, 8'h2B: begin
                        is_paset_q <= (byte_data_q == 8'h2B);
                        state_q    <= PARAM;
                    end
                    8'h2C: begin
                        cur_x_q <= win_xs_q;
                        cur_y_q <= win_ys_q;
                        state_q <= RAMWR_HI;
                    end
                    default: ;
                endcase
            end else if (byte_valid_q) begin
                case (state_q)
                    PARAM: begin
                        if (pidx_q < 3'd4) begin
                            pidx_q <= pidx_q + 3'd1;
                            case (pidx_q)
                                3'd0: p0_q <= byte_data_q;
                                3'd1: p1_q <= byte_data_q;
                                3'd2: p2_q <= byte_data_q;
                                default: begin
                                    if (is_paset_q) begin
                                        win_ys_q <= clamp({p0_q, p1_q}, YM16);
                                        win_ye_q <= clamp({p2_q, byte_data_q}, YM16);
                                    end else begin
                                        win_xs_q <= clamp({p0_q, p1_q}, XM16);
                                        win_xe_q <= clamp({p2_q, byte_data_q}, XM16);
                                    end
                                end
                            endcase
                        end
                    end
                    RAMWR_HI: begin
                        hi_q    <= byte_data_q;
                        state_q <= RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        state_q <= RAMWR_HI;
                        if (win_ok) begin
                            pix_valid_q <= 1'b1;
                            pix_x_q     <= cur_x_q;
                            pix_y_q     <= cur_y_q;
                            pix_data_q  <= {hi_q, byte_data_q};
                            cur_x_q     <= cur_x_d;
                            cur_y_q     <= cur_y_d;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign cmd_valid  = cmd_valid_q;
    assign last_cmd   = last_cmd_q;
    assign sleep_out  = sleep_q;
    assign disp_on    = disp_q;
    assign win_xs     = win_xs_q;
    assign win_xe     = win_xe_q;
    assign win_ys     = win_ys_q;
    assign win_ye     = win_ye_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_ili9341_spi_sink.sv
module tb_ili9341_spi_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_dc = 1'b0;
    logic        byte_valid, byte_dc, cmd_valid, sleep_out, disp_on, pix_valid;
    logic [7:0]  byte_data, last_cmd;
    logic [8:0]  win_xs, win_xe, win_ys, win_ye, pix_x, pix_y;
    logic [15:0] pix_data;

    ili9341_spi_sink #(.X_MAX(239), .Y_MAX(319)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .cmd_valid(cmd_valid), .last_cmd(last_cmd),
        .sleep_out(sleep_out), .disp_on(disp_on),
        .win_xs(win_xs), .win_xe(win_xe), .win_ys(win_ys), .win_ye(win_ye),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bv_n = 0;
    int bv_cyc = 0;
    int cmd_n = 0;
    int c0 = 0;
    logic [7:0]  bv_dat = 8'h00;
    logic        bv_dc = 1'b0;
    logic [33:0] pix_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_n++;
            bv_cyc = cyc;
            bv_dat = byte_data;
            bv_dc  = byte_dc;
        end
        if (cmd_valid) cmd_n++;
        if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_data});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // One SPI bit per 8 clk (4 low, 4 high); c0 records the edge that first sees bit 0 high.
    task automatic send_bits(input int n, input logic [7:0] b);
        spi_cs_n = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            tick(4);
            spi_sclk = 1'b1;
            if (i == 0) begin
                @(posedge clk);
                #1;
                c0 = cyc;
                #2;
                tick(3);
            end else begin
                tick(4);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        spi_dc = dc;
        send_bits(8, b);
        tick(8);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic [7:0] exp_last;
        logic       exp_sleep;
        logic       exp_disp;
    } vec_t;

    vec_t tbl[7];

    logic [8:0] init_seq [47] = '{
        9'h0EF, 9'h103, 9'h180, 9'h102,
        9'h0CF, 9'h100, 9'h1C1, 9'h130,
        9'h0ED, 9'h164, 9'h103, 9'h112, 9'h181,
        9'h0E8, 9'h185, 9'h100, 9'h178,
        9'h0CB, 9'h139, 9'h12C, 9'h100, 9'h134, 9'h102,
        9'h0C5, 9'h13E, 9'h128,
        9'h0EA, 9'h100, 9'h100,
        9'h0B6, 9'h108, 9'h182, 9'h127,
        9'h0B1, 9'h100, 9'h118,
        9'h0E0, 9'h10F, 9'h131,
        9'h011,
        9'h029,
        9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
        9'h02C
    };

    initial begin
        int bv0, cm0, pc;
        logic [33:0] p;
        int ex_x[5] = '{10, 11, 10, 11, 10};
        int ex_y[5] = '{5, 5, 6, 6, 5};

        tbl[0] = '{1'b0, 8'h11, 8'h11, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h29, 8'h29, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'h28, 8'h28, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h11, 8'h11, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h29, 8'h29, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h55, 8'h29, 1'b1, 1'b1};

        // Reset state
        tick(4);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_last_cmd", last_cmd, 8'h00);
        chk("rst_sleep", sleep_out, 1'b0);
        chk("rst_disp", disp_on, 1'b0);
        chk("rst_win", {win_xs, win_xe, win_ys, win_ye}, {9'd0, 9'd239, 9'd0, 9'd319});
        chk("rst_pix_valid", pix_valid, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Table-driven command/data bytes
        for (int i = 0; i < 7; i++) begin
            bv0 = bv_n;
            cm0 = cmd_n;
            send_byte(tbl[i].dc, tbl[i].b);
            chk($sformatf("tbl%0d_bv_cnt", i), bv_n - bv0, 1);
            chk($sformatf("tbl%0d_latency", i), bv_cyc - c0, 4);
            chk($sformatf("tbl%0d_data", i), {bv_dc, bv_dat}, {tbl[i].dc, tbl[i].b});
            chk($sformatf("tbl%0d_cmd_cnt", i), cmd_n - cm0, tbl[i].dc ? 0 : 1);
            chk($sformatf("tbl%0d_last_cmd", i), last_cmd, tbl[i].exp_last);
            chk($sformatf("tbl%0d_sleep_disp", i), {sleep_out, disp_on}, {tbl[i].exp_sleep, tbl[i].exp_disp});
        end

        // Windowed RAMWR with raster wrap
        pix_q.delete();
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        chk("win_10_11_5_6", {win_xs, win_xe, win_ys, win_ye}, {9'd10, 9'd11, 9'd5, 9'd6});
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) begin
            dat(8'hF8);
            dat(8'h00);
        end
        pc = pix_q.size();
        chk("ramwr_pix_count", pc, 5);
        for (int i = 0; i < 5 && i < pc; i++) begin
            p = pix_q.pop_front();
            chk($sformatf("pix%0d", i), p, {ex_x[i][8:0], ex_y[i][8:0], 16'hF800});
        end

        // CASET clamp, then a truncated CASET
        cmd(8'h2A); dat(8'h00); dat(8'h14); dat(8'h01); dat(8'hFF);
        chk("caset_clamp", {win_xs, win_xe}, {9'd20, 9'd239});
        cmd(8'h2A); dat(8'h00); dat(8'h01);
        cmd(8'h2C);
        chk("caset_short", {win_xs, win_xe}, {9'd20, 9'd239});

        // Partial byte discarded on deselect
        bv0 = bv_n;
        spi_dc = 1'b1;
        send_bits(5, 8'hD8);
        spi_cs_n = 1'b1;
        tick(8);
        spi_cs_n = 1'b0;
        tick(8);
        dat(8'hA5);
        chk("partial_bv_cnt", bv_n - bv0, 1);
        chk("partial_data", bv_dat, 8'hA5);

        // Odd RAMWR byte dropped by a following command
        pix_q.delete();
        cmd(8'h2C);
        cm0 = cmd_n;
        dat(8'h12); dat(8'h34); dat(8'h56);
        cmd(8'h00);
        pc = pix_q.size();
        chk("odd_pix_count", pc, 1);
        if (pc > 0) begin
            p = pix_q.pop_front();
            chk("odd_pix", p, {9'd20, 9'd5, 16'h1234});
        end
        chk("odd_cmd_cnt", cmd_n - cm0, 1);
        chk("odd_last_cmd", last_cmd, 8'h00);

        // Inverted window: bytes consumed, no pixels
        pix_q.delete();
        cmd(8'h2B); dat(8'h00); dat(8'h09); dat(8'h00); dat(8'h03);
        cmd(8'h2C);
        for (int i = 0; i < 4; i++) dat(8'h77);
        pc = pix_q.size();
        chk("inv_win_pix_count", pc, 0);

        // Async reset mid-byte
        spi_dc = 1'b0;
        send_bits(4, 8'hF0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("arst_last_cmd", last_cmd, 8'h00);
        chk("arst_state", {sleep_out, disp_on}, 2'b00);
        chk("arst_win", {win_ys, win_ye}, {9'd0, 9'd319});
        spi_cs_n = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        cmd(8'h11);
        chk("arst_next_byte", bv_dat, 8'h11);
        chk("arst_next_sleep", sleep_out, 1'b1);

        // Init sequence replay
        cm0 = cmd_n;
        for (int i = 0; i < 47; i++) begin
            send_byte(init_seq[i][8], init_seq[i][7:0]);
            if (init_seq[i] == 9'h011) tick(60);
        end
        chk("init_cmd_cnt", cmd_n - cm0, 14);
        chk("init_last_cmd", last_cmd, 8'h2C);
        chk("init_sleep_disp", {sleep_out, disp_on}, 2'b11);
        chk("init_win_x", {win_xs, win_xe}, {9'd0, 9'd239});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ili9341_spi_sink.md
Name: ili9341_spi_sink

Overview:
- Display-side receiver for the 4-wire SPI + D/C stream our ILI9341 init/pixel driver emits.
- Deserialises 9-bit {dc, byte} transactions and decodes the command set the driver uses: sleep/display state, column/page window, RAMWR pixel stream.
- Sits in the loopback/self-test path and on the bench as a synthesizable panel model. It produces pixel write strobes with x/y coordinates so the driver output can be checked on-chip.

Parameters:
- X_MAX, 239, last valid column index (portrait 240 wide).
- Y_MAX, 319, last valid page index (320 tall).

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- rst_n  in  1  reset, asynchronous and active-low.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = data/parameter byte.
- byte_valid  out  1  one-cycle strobe: a complete byte was received.
- byte_data  out  8  received byte; valid with byte_valid.
- byte_dc  out  1  dc sampled with bit 0 of the byte; valid with byte_valid.
- cmd_valid  out  1  one-cycle strobe on a command byte (byte_valid & ~byte_dc).
- last_cmd  out  8  most recent command byte; held.
- sleep_out  out  1  1 after 0x11, 0 after 0x10.
- disp_on  out  1  1 after 0x29, 0 after 0x28.
- win_xs, win_xe  out  9  column window from CASET.
- win_ys, win_ye  out  9  page window from PASET.
- pix_valid  out  1  one-cycle strobe: an RGB565 pixel was written.
- pix_x, pix_y  out  9  coordinate of the written pixel.
- pix_data  out  16  RGB565 pixel, first byte in bits [15:8].

Behaviour:
- Reset values: all strobes 0, byte_data/last_cmd/pix_* 0, sleep_out 0, disp_on 0. win_xs = 0, win_xe = X_MAX, win_ys = 0, win_ye = Y_MAX. FSM in CMD_WAIT, bit counter 0.
- Input sync: sclk, mosi, cs_n and dc each pass through a 2-flop synchroniser. A rising edge is detected when sync2 = 1 and the previous sync2 = 0.
- Bit capture: on a detected rise with cs_n_sync = 0, shift mosi in and increment the 3-bit counter. dc is latched on the 8th bit.
- Byte output: byte_valid is registered and goes high exactly 4 clk cycles after the first clk edge that samples raw spi_sclk high for bit 0 (bit 0 = LSB, last bit shifted).
- cs_n_sync high clears the bit counter and discards any partial byte. Decode context (current command, param index, cursor) is retained.
- Decoder FSM states: CMD_WAIT, PARAM, RAMWR_HI, RAMWR_LO. Each cmd_valid updates last_cmd and resets the param index to 0.
  - 0x11/0x10/0x29/0x28: update sleep_out/disp_on; go to CMD_WAIT.
  - 0x2A CASET / 0x2B PASET: go to PARAM. Parameters arrive in the order start hi, start lo, end hi, end lo.
  - On the 4th parameter, commit start and end together. Each 16-bit value is clamped to X_MAX (CASET) or Y_MAX (PASET).
  - Fewer than 4 parameters followed by a new command leaves the window unchanged. Parameters beyond the 4th are ignored.
  - 0x2C RAMWR: cursor loads (win_xs, win_ys); go to RAMWR_HI.
  - Any other command: its parameters are ignored; stay in CMD_WAIT.
- RAMWR:
  - A data byte in RAMWR_HI is stored; go to RAMWR_LO.
  - A data byte in RAMWR_LO raises pix_valid in the next cycle with the pre-increment cursor, then goes to RAMWR_HI.
  - Cursor advance: if x == win_xe, then x = win_xs and y increments; if y == win_ye as well, y = win_ys (full-window wrap).
  - If win_xs > win_xe or win_ys > win_ye, no pix_valid is raised, bytes are consumed, and the cursor is held.
  - A command byte in RAMWR_LO drops the odd byte and is then decoded normally.
- A command byte may arrive at any state and always takes priority.
- Async reset mid-byte or mid-RAMWR restores all reset values immediately.

Test Plan:
- Reset, then send cmd 0x11 then 0x29: two cmd_valid pulses, last_cmd = 0x29, sleep_out = 1, disp_on = 1; byte_valid at exactly 4 clk after the first bit-0 sample.
- CASET 00 0A 00 0B, PASET 00 05 00 06, RAMWR, then 10 data bytes 0xF8 0x00 repeated: pixels at (10,5),(11,5),(10,6),(11,6),(10,5), all pix_data 0xF800.
- CASET 00 14 01 FF: win_xs = 20, win_xe = 239 (clamped); CASET with only 2 params then 0x2C: window unchanged.
- Deassert cs_n after 5 bits, reassert, send a full byte 0xA5: one byte_valid with 0xA5, partial byte discarded.
- RAMWR, 3 data bytes, then cmd 0x00: exactly one pix_valid, odd byte dropped, cmd_valid for 0x00.
- Replay the full 47-entry init sequence via the driver (sim delays): final last_cmd = 0x2C, 14 cmd_valid pulses, sleep_out = 1, disp_on = 1.
